// File: rtl/seq_shifter_if.sv
// Handshake/data bundle between the controller and the multi-cycle shifter.
// Optional carry output present when SHIFTER_CARRY_EN is defined.
interface seq_shifter_if #(
   parameter int DSIZE  = 16,
   parameter int OPSIZE = 3,
   parameter int ASIZE  = 4
);
   logic              start;
   logic [OPSIZE-1:0] op;
   logic [ASIZE-1:0]  amt;
   logic [DSIZE-1:0]  data_b;
   logic [DSIZE-1:0]  f;
   logic              busy;
   logic              done;
`ifdef SHIFTER_CARRY_EN
   logic              carry;

   modport master (output start, op, amt, data_b, input f, busy, done, carry);
   modport slave  (input start, op, amt, data_b, output f, busy, done, carry);
`else
   modport master (output start, op, amt, data_b, input f, busy, done);
   modport slave  (input start, op, amt, data_b, output f, busy, done);
`endif
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit moving up to STEP bit positions per clock.
// Optional registered carry output enabled by defining SHIFTER_CARRY_EN.
module seq_shifter #(
   parameter int DSIZE  = 16,
   parameter int OPSIZE = 3,
   parameter int ASIZE  = 4,
   parameter int STEP   = 4
) (
   input logic          clk,
   input logic          rst,
   seq_shifter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam logic [OPSIZE-1:0] OP_SRL = OPSIZE'(0);
   localparam logic [OPSIZE-1:0] OP_SLL = OPSIZE'(1);
   localparam logic [OPSIZE-1:0] OP_ROR = OPSIZE'(2);
   localparam logic [OPSIZE-1:0] OP_ROL = OPSIZE'(3);
   localparam logic [OPSIZE-1:0] OP_SRA = OPSIZE'(4);
   localparam logic [ASIZE-1:0]  STEP_A = ASIZE'(STEP);

   state_t            state_q, state_d;
   logic [OPSIZE-1:0] op_q, op_d;
   logic [ASIZE-1:0]  rem_q, rem_d;
   logic [DSIZE-1:0]  work_q, work_d;
   logic [DSIZE-1:0]  f_q, f_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [ASIZE-1:0]  step_s;
   logic [ASIZE:0]    inv_s;
   logic [DSIZE-1:0]  shifted_s;

   // Chunk size for this cycle and the work register shifted by it.
   always_comb begin
      step_s    = (rem_q < STEP_A) ? rem_q : STEP_A;
      inv_s     = (ASIZE+1)'(DSIZE) - {1'b0, step_s};
      shifted_s = work_q;
      case (op_q)
         OP_SRL:  shifted_s = work_q >> step_s;
         OP_SLL:  shifted_s = work_q << step_s;
         OP_ROR:  shifted_s = (work_q >> step_s) | (work_q << inv_s);
         OP_ROL:  shifted_s = (work_q << step_s) | (work_q >> inv_s);
         OP_SRA:  shifted_s = DSIZE'($signed(work_q) >>> step_s);
         default: shifted_s = work_q;
      endcase
   end

`ifdef SHIFTER_CARRY_EN
   logic cw_q, cw_d;
   logic carry_q, carry_d;
   logic step_bit_s;

   // Bit leaving the register this cycle: LSB end for right moves, MSB end for left.
   always_comb begin
      step_bit_s = 1'b0;
      if (step_s != ASIZE'(0)) begin
         case (op_q)
            OP_SRL, OP_SRA, OP_ROR: step_bit_s = work_q[ASIZE'(step_s - ASIZE'(1))];
            OP_SLL, OP_ROL:         step_bit_s = work_q[inv_s[ASIZE-1:0]];
            default:                step_bit_s = 1'b0;
         endcase
      end else begin
         step_bit_s = 1'b0;
      end
   end
`endif

   // Next-state, datapath updates and registered handshake outputs.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rem_d   = rem_q;
      work_d  = work_q;
      f_d     = f_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef SHIFTER_CARRY_EN
      cw_d    = cw_q;
      carry_d = carry_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               op_d    = bus.op;
               work_d  = bus.data_b;
               // Pass-through opcodes finish on the first edge, like amt=0.
               rem_d   = (bus.op > OP_SRA) ? ASIZE'(0) : bus.amt;
               busy_d  = 1'b1;
               state_d = SHIFT;
`ifdef SHIFTER_CARRY_EN
               cw_d    = 1'b0;
`endif
            end else begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         SHIFT: begin
            work_d = shifted_s;
            rem_d  = rem_q - step_s;
`ifdef SHIFTER_CARRY_EN
            if (step_s != ASIZE'(0)) begin
               cw_d = step_bit_s;
            end else begin
               cw_d = cw_q;
            end
`endif
            if (rem_q <= STEP_A) begin
               f_d     = shifted_s;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
`ifdef SHIFTER_CARRY_EN
               carry_d = (step_s != ASIZE'(0)) ? step_bit_s : cw_q;
`endif
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OPSIZE'(0);
         rem_q   <= ASIZE'(0);
         work_q  <= DSIZE'(0);
         f_q     <= DSIZE'(0);
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SHIFTER_CARRY_EN
         cw_q    <= 1'b0;
         carry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         work_q  <= work_d;
         f_q     <= f_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SHIFTER_CARRY_EN
         cw_q    <= cw_d;
         carry_q <= carry_d;
`endif
      end
   end

   assign bus.f    = f_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
`ifdef SHIFTER_CARRY_EN
   assign bus.carry = carry_q;
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed cases plus randomized ops
// against an arithmetic reference model (DSIZE=16, STEP=4).
module tb_seq_shifter;

   localparam int DSIZE = 16;
   localparam int STEP  = 4;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   seq_shifter_if #(.DSIZE(16), .OPSIZE(3), .ASIZE(4)) sif ();

   seq_shifter #(.DSIZE(16), .OPSIZE(3), .ASIZE(4), .STEP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] m_f(input logic [2:0] o, input int a, input logic [15:0] d);
      logic [31:0] t;
      case (o)
         3'd0: return d >> a;
         3'd1: return d << a;
         3'd2: begin t = {d, d} >> a; return t[15:0]; end
         3'd3: begin t = {d, d} << a; return t[31:16]; end
         3'd4: return (d >> a) | (d[15] ? ~(16'hFFFF >> a) : 16'h0000);
         default: return d;
      endcase
   endfunction

   function automatic int m_k(input logic [2:0] o, input int a);
      if (o > 3'd4 || a == 0) return 1;
      return (a + STEP - 1) / STEP;
   endfunction

   function automatic logic m_c(input logic [2:0] o, input int a, input logic [15:0] d);
      if (o > 3'd4 || a == 0) return 1'b0;
      if (o == 3'd1 || o == 3'd3) return d[DSIZE - a];
      return d[a - 1];
   endfunction

   // Launch one op from an idle or DONE cycle; returns result, latency, busy cycles
   // and whether f moved before done.
   task automatic do_op(input logic [2:0] o, input logic [3:0] a, input logic [15:0] d,
                        output logic [15:0] fo, output int cyc, output int bcnt,
                        output bit moved);
      logic [15:0] f0;
      sif.start = 1'b1; sif.op = o; sif.amt = a; sif.data_b = d;
      @(posedge clk); #1;
      f0 = sif.f;
      sif.start = 1'b0;
      sif.op = 3'($urandom); sif.amt = 4'($urandom); sif.data_b = 16'($urandom);
      cyc = -1; bcnt = 0; moved = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (sif.busy) bcnt++;
         if (sif.f !== f0) moved = 1'b1;
         @(posedge clk); #1;
         if (sif.done) begin
            cyc = c;
            break;
         end
      end
      fo = sif.f;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sif.start = 1'b0; sif.op = 3'd0; sif.amt = 4'd0; sif.data_b = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (sif.f !== 16'h0000 || sif.busy !== 1'b0 || sif.done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: f=%h busy=%b done=%b, expected 0000/0/0", sif.f, sif.busy, sif.done);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b done=%b, expected 0/0", sif.busy, sif.done);
      end
   endtask

   task automatic test_srl();
      logic [15:0] fo; int cyc, bcnt; bit mv;
      do_op(3'd0, 4'd1, 16'h8001, fo, cyc, bcnt, mv);
      n_tests++;
      if (fo !== 16'h4000 || cyc != 1 || bcnt != 1) begin
         n_fail++;
         $display("FAIL srl_amt1: f=%h k=%0d busy=%0d, expected 4000 k=1 busy=1", fo, cyc, bcnt);
      end
      n_tests++;
      if (sif.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL srl_busy_at_done: busy=%b, expected 0", sif.busy);
      end
      @(posedge clk); #1;
      n_tests++;
      if (sif.done !== 1'b0 || sif.f !== 16'h4000) begin
         n_fail++;
         $display("FAIL srl_done_pulse: done=%b f=%h, expected 0 4000", sif.done, sif.f);
      end
   endtask

   task automatic test_sra();
      logic [15:0] fo; int cyc, bcnt; bit mv;
      do_op(3'd4, 4'd15, 16'h8000, fo, cyc, bcnt, mv);
      n_tests++;
      if (fo !== 16'hFFFF || cyc != 4 || mv) begin
         n_fail++;
         $display("FAIL sra_neg: f=%h k=%0d moved=%b, expected ffff k=4 moved=0", fo, cyc, mv);
      end
      @(posedge clk); #1;
      do_op(3'd4, 4'd15, 16'h4000, fo, cyc, bcnt, mv);
      n_tests++;
      if (fo !== 16'h0000 || cyc != 4) begin
         n_fail++;
         $display("FAIL sra_pos: f=%h k=%0d, expected 0000 k=4", fo, cyc);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [15:0] fo; int cyc, bcnt; bit mv;
      do_op(3'd3, 4'd4, 16'h8001, fo, cyc, bcnt, mv);
      n_tests++;
      if (fo !== 16'h0018 || cyc != 1) begin
         n_fail++;
         $display("FAIL rol_4: f=%h k=%0d, expected 0018 k=1", fo, cyc);
      end
      do_op(3'd2, 4'd8, 16'h1234, fo, cyc, bcnt, mv);
      n_tests++;
      if (fo !== 16'h3412 || cyc != 2 || mv) begin
         n_fail++;
         $display("FAIL ror_8_b2b: f=%h k=%0d moved=%b, expected 3412 k=2 moved=0", fo, cyc, mv);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_amt0_and_ignore();
      logic [15:0] fo; int cyc, bcnt; bit mv; int dones;
      do_op(3'd1, 4'd0, 16'h00F0, fo, cyc, bcnt, mv);
      n_tests++;
      if (fo !== 16'h00F0 || cyc != 1) begin
         n_fail++;
         $display("FAIL sll_amt0: f=%h k=%0d, expected 00f0 k=1", fo, cyc);
      end
      @(posedge clk); #1;
      sif.start = 1'b1; sif.op = 3'd4; sif.amt = 4'd15; sif.data_b = 16'h8F00;
      @(posedge clk); #1;
      sif.start = 1'b0;
      @(posedge clk); #1;
      sif.start = 1'b1; sif.op = 3'd0; sif.amt = 4'd2; sif.data_b = 16'hFFFF;
      @(posedge clk); #1;
      sif.start = 1'b0;
      dones = 0;
      for (int c = 0; c < 10; c++) begin
         if (sif.done) begin
            dones++;
            n_tests++;
            if (sif.f !== 16'hFFFF) begin
               n_fail++;
               $display("FAIL ignore_result: f=%h, expected ffff", sif.f);
            end
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (dones != 1) begin
         n_fail++;
         $display("FAIL ignore_done_count: dones=%0d, expected 1", dones);
      end
   endtask

   task automatic test_reset_abort();
      logic [15:0] fo; int cyc, bcnt; bit mv; int dones;
      sif.start = 1'b1; sif.op = 3'd1; sif.amt = 4'd12; sif.data_b = 16'h0001;
      @(posedge clk); #1;
      sif.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_tests++;
      if (sif.f !== 16'h0000 || sif.busy !== 1'b0 || sif.done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_rst: f=%h busy=%b done=%b, expected 0000/0/0", sif.f, sif.busy, sif.done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (sif.done) dones++;
      end
      n_tests++;
      if (dones != 0 || sif.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: dones=%0d busy=%b, expected 0 0", dones, sif.busy);
      end
      do_op(3'd1, 4'd12, 16'h0001, fo, cyc, bcnt, mv);
      n_tests++;
      if (fo !== 16'h1000 || cyc != 3) begin
         n_fail++;
         $display("FAIL sll_after_abort: f=%h k=%0d, expected 1000 k=3", fo, cyc);
      end
      @(posedge clk); #1;
   endtask

`ifdef SHIFTER_CARRY_EN
   task automatic test_carry();
      logic [15:0] fo; int cyc, bcnt; bit mv;
      do_op(3'd1, 4'd1, 16'h8000, fo, cyc, bcnt, mv);
      n_tests++;
      if (fo !== 16'h0000 || sif.carry !== 1'b1) begin
         n_fail++;
         $display("FAIL carry_sll: f=%h carry=%b, expected 0000 1", fo, sif.carry);
      end
      do_op(3'd0, 4'd1, 16'h0002, fo, cyc, bcnt, mv);
      n_tests++;
      if (fo !== 16'h0001 || sif.carry !== 1'b0) begin
         n_fail++;
         $display("FAIL carry_srl: f=%h carry=%b, expected 0001 0", fo, sif.carry);
      end
      do_op(3'd2, 4'd1, 16'h0001, fo, cyc, bcnt, mv);
      n_tests++;
      if (fo !== 16'h8000 || sif.carry !== 1'b1) begin
         n_fail++;
         $display("FAIL carry_ror: f=%h carry=%b, expected 8000 1", fo, sif.carry);
      end
      @(posedge clk); #1;
   endtask
`endif

   task automatic test_random();
      logic [15:0] fo, d; logic [2:0] o; logic [3:0] a;
      int cyc, bcnt, gap; bit mv;
      for (int i = 0; i < 60; i++) begin
         o = 3'($urandom_range(0, 7));
         a = 4'($urandom_range(0, 15));
         d = 16'($urandom);
         do_op(o, a, d, fo, cyc, bcnt, mv);
         n_tests++;
         if (fo !== m_f(o, int'(a), d) || cyc != m_k(o, int'(a)) || bcnt != cyc
             || mv || sif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand[%0d] op=%0d amt=%0d d=%h: f=%h k=%0d busy=%0d moved=%b, expected f=%h k=%0d",
                     i, o, a, d, fo, cyc, bcnt, mv, m_f(o, int'(a), d), m_k(o, int'(a)));
         end
`ifdef SHIFTER_CARRY_EN
         n_tests++;
         if (sif.carry !== m_c(o, int'(a), d)) begin
            n_fail++;
            $display("FAIL rand_carry[%0d] op=%0d amt=%0d d=%h: carry=%b, expected %b",
                     i, o, a, d, sif.carry, m_c(o, int'(a), d));
         end
`endif
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_srl();
      test_sra();
      test_back_to_back();
      test_amt0_and_ignore();
      test_reset_abort();
`ifdef SHIFTER_CARRY_EN
      test_carry();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle, parametrised shift/rotate unit; successor to the 4-op single-bit combinational shifter in the datapath.
- Supports a variable shift amount, arithmetic right shift, and a configurable number of bit positions per clock (STEP). This lets wide shifts trade latency for area.
- Sits beside the ALU; the controller launches it with a start/done handshake and reads f when done pulses.

Parameters:
- DSIZE, 16, data width; power of two, >= 4.
- OPSIZE, 3, opcode width.
- ASIZE, 4, shift-amount width; must equal log2(DSIZE).
- STEP, 4, maximum bit positions shifted per clock; 1 <= STEP <= DSIZE-1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- op  input  OPSIZE  000 SRL, 001 SLL, 010 ROR, 011 ROL, 100 SRA, 101-111 pass-through.
- amt  input  ASIZE  shift amount, 0..DSIZE-1, unsigned.
- data_b  input  DSIZE  operand.
- f  output  DSIZE  result register.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; f valid from this cycle on.

Behaviour:
- Reset: asynchronous, active-high. While rst=1: state=IDLE, f=0, busy=0, done=0, remaining-count=0, internal work register=0.
- States:
  - IDLE: start=1 at an edge -> capture data_b, op and amt ("edge 0"). Set busy=1 and go to SHIFT.
  - SHIFT: each edge shifts the work register by s=min(remaining, STEP) and sets remaining -= s. When remaining reaches 0 (or amt was 0), go to DONE: f <= work register, done=1, busy=0.
  - DONE: lasts one cycle. start=1 at that edge is accepted exactly as in IDLE (back-to-back issue). Otherwise go to IDLE, done=0.
- Latency: done is high in the cycle after edge K, where K = max(1, ceil(amt/STEP)). With the defaults: amt=0 -> K=1, amt=5 -> K=2, amt=15 -> K=4.
- Arithmetic:
  - SRL and SLL are zero-filling.
  - SRA fills with the captured MSB.
  - ROR and ROL wrap modulo DSIZE.
  - A total shift of amt in chunks of s is bit-exact to a single shift of amt.
- Pass-through opcodes and amt=0: f = captured data_b, K=1.
- f holds its value until the next operation reaches DONE. The intermediate value is never visible on f.
- start while busy=1: ignored, no queueing, inputs not re-sampled.
- Inputs op, amt and data_b may change freely after edge 0.
- rst asserted mid-operation: aborts at once; done is not pulsed and f returns to 0.
- done and busy are never high together. busy falls in the same cycle that done rises.

Optional Feature:
- Macro SHIFTER_CARRY_EN.
- When defined:
  - Extra output port carry (1 bit, registered), updated with f.
  - SRL, SRA and ROR: carry = the last bit shifted out of the LSB end.
  - SLL and ROL: carry = the last bit shifted out of the MSB end.
  - For rotates this equals f[DSIZE-1] after ROR and f[0] after ROL.
  - amt=0 or pass-through: carry=0. Reset value 0.
- When not defined: no carry port and no carry logic; all other behaviour is identical.

Test Plan:
All cases use DSIZE=16, STEP=4.
1. SRL, data_b=0x8001, amt=1 -> f=0x4000, done one cycle after edge 1, busy high for exactly 1 cycle.
2. SRA, data_b=0x8000, amt=15 -> f=0xFFFF, done after edge 4. Then SRA data_b=0x4000, amt=15 -> f=0x0000.
3. ROL, 0x8001, amt=4 -> f=0x0018 (K=1). ROR, 0x1234, amt=8 -> f=0x3412 (K=2), issued back-to-back in the DONE cycle.
4. SLL, 0x00F0, amt=0 -> f=0x00F0, K=1. Start pulsed while busy (SRL 0xFFFF, amt=2 during a 15-bit SRA) -> ignored, only one done, SRA result unchanged.
5. SLL, 0x0001, amt=12, then rst pulsed after edge 2 -> f=0, busy=0, no done; next SLL 0x0001 amt=12 -> f=0x1000 after edge 3.
6. With SHIFTER_CARRY_EN defined: SLL 0x8000 amt=1 -> f=0x0000, carry=1; SRL 0x0002 amt=1 -> carry=0; ROR 0x0001 amt=1 -> f=0x8000, carry=1.
